// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ============================================================================
// dbus_sram_responder : word-organised SRAM responder for the core's dbus port
//                       with a fixed request-to-data_ok latency.
// Revision 1.0
// ============================================================================
module dbus_sram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        enter_resp;
  logic        accept;

  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  strobe_q;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0]   src_addr;
  logic [2:0]    src_size;
  logic [3:0]    src_strobe;
  logic          src_err;
  logic [AW-1:0] src_idx;
  logic [AW-1:0] idx_q;
  logic [31:0]   rd_word;
  logic          mem_we;

  function automatic logic calc_err(input logic [31:0] a, input logic [2:0] s);
    logic oor;
    oor = (a >> (AW + 2)) != 32'd0;
    return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || oor;
  endfunction

  assign accept = (state == S_IDLE) && req_valid;

  // With LATENCY 1 the response is entered on the acceptance edge, so the
  // decode must look at the live request rather than the latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      src_addr   = req_addr;
      src_size   = req_size;
      src_strobe = req_strobe;
    end else begin
      src_addr   = addr_q;
      src_size   = size_q;
      src_strobe = strobe_q;
    end
  end

  assign src_err = calc_err(src_addr, src_size);
  assign src_idx = src_addr[AW+1:2];
  assign idx_q   = addr_q[AW+1:2];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY <= 1) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
            cnt_nxt    = 4'd0;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_q   <= 32'd0;
      size_q   <= 3'd0;
      strobe_q <= 4'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        strobe_q <= req_strobe;
        data_q   <= req_data;
      end
      if (enter_resp) begin
        err_q   <= src_err;
        rdata_q <= (src_err || src_strobe != 4'd0) ? 32'd0 : rd_word;
      end
    end
  end

  // Write lands on the edge that closes RESP; a reset during the request
  // forces IDLE first, so an aborted write never reaches the array.
  assign mem_we = (state == S_RESP) && (strobe_q != 4'd0) && !err_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] bank [MEM_WORDS];

    always_ff @(posedge clk) begin
      if (mem_we && strobe_q[i]) begin
        bank[idx_q] <= data_q[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = bank[src_idx];
  end

  assign resp_addr_ok = resetn && accept;
  assign resp_data_ok = (state == S_RESP);
  assign resp_data    = (state == S_RESP) ? rdata_q : 32'd0;
  assign resp_err     = (state == S_RESP) && err_q;
  assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_dbus_sram_responder : two responders (LATENCY 2 / LATENCY 1) checked
//                          against a transaction-level memory model.
// Revision 1.0
// ============================================================================
module tb_dbus_sram_responder;

  localparam int MW_A  = 1024;
  localparam int MW_B  = 16;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn       [2];
  logic        req_valid    [2];
  logic [31:0] req_addr     [2];
  logic [2:0]  req_size     [2];
  logic [3:0]  req_strobe   [2];
  logic [31:0] req_data     [2];
  logic        resp_addr_ok [2];
  logic        resp_data_ok [2];
  logic [31:0] resp_data    [2];
  logic        resp_err     [2];
  logic        busy         [2];

  dbus_sram_responder #(.MEM_WORDS(MW_A), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_size(req_size[0]), .req_strobe(req_strobe[0]), .req_data(req_data[0]),
    .resp_addr_ok(resp_addr_ok[0]), .resp_data_ok(resp_data_ok[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  dbus_sram_responder #(.MEM_WORDS(MW_B), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_size(req_size[1]), .req_strobe(req_strobe[1]), .req_data(req_data[1]),
    .resp_addr_ok(resp_addr_ok[1]), .resp_data_ok(resp_data_ok[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  function automatic int mw(input int k);
    return (k == 0) ? MW_A : MW_B;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit model_err(input int k, input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && (a % 2) != 0) return 1'b1;
    if (s == 3'd2 && (a % 4) != 0) return 1'b1;
    return longint'(a) >= longint'(mw(k)) * 4;
  endfunction

  // Transaction model: one outstanding request per responder, answered
  // LATENCY cycles after the cycle it was accepted in.
  bit          pend   [2];
  int          due    [2];
  int          cyc    [2];
  logic [31:0] m_addr [2];
  logic [2:0]  m_size [2];
  logic [3:0]  m_strb [2];
  logic [31:0] m_data [2];
  logic [31:0] mm     [2][1024];
  logic [3:0]  kn     [2][1024];
  bit          ea, ed;
  int          w;
  logic [31:0] mask;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn[k]) begin
        check("rst_addr_ok", k, 32'(resp_addr_ok[k]), 32'd0);
        check("rst_data_ok", k, 32'(resp_data_ok[k]), 32'd0);
        check("rst_data",    k, resp_data[k],         32'd0);
        check("rst_err",     k, 32'(resp_err[k]),     32'd0);
        check("rst_busy",    k, 32'(busy[k]),         32'd0);
        pend[k] = 1'b0;
      end else begin
        ea = req_valid[k] && !pend[k];
        ed = pend[k] && (cyc[k] == due[k]);
        check("addr_ok", k, 32'(resp_addr_ok[k]), 32'(ea));
        check("data_ok", k, 32'(resp_data_ok[k]), 32'(ed));
        check("busy",    k, 32'(busy[k]),         32'(pend[k]));
        if (ed) begin
          w = int'(m_addr[k] / 4);
          if (model_err(k, m_addr[k], m_size[k])) begin
            check("err",  k, 32'(resp_err[k]), 32'd1);
            check("data", k, resp_data[k],     32'd0);
          end else if (m_strb[k] != 4'd0) begin
            check("err",  k, 32'(resp_err[k]), 32'd0);
            check("data", k, resp_data[k],     32'd0);
            for (int b = 0; b < 4; b++) begin
              if (m_strb[k][b]) begin
                mm[k][w][8*b +: 8] = m_data[k][8*b +: 8];
                kn[k][w][b] = 1'b1;
              end
            end
          end else begin
            check("err", k, 32'(resp_err[k]), 32'd0);
            mask = 32'd0;
            for (int b = 0; b < 4; b++) if (kn[k][w][b]) mask[8*b +: 8] = 8'hFF;
            if (mask != 32'd0) check("rdata", k, resp_data[k] & mask, mm[k][w] & mask);
          end
          pend[k] = 1'b0;
        end
        if (ea) begin
          pend[k]   = 1'b1;
          due[k]    = cyc[k] + lat(k);
          m_addr[k] = req_addr[k];
          m_size[k] = req_size[k];
          m_strb[k] = req_strobe[k];
          m_data[k] = req_data[k];
        end
        cyc[k]++;
      end
    end
  end

  task automatic txn(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [3:0] sb,
                     input logic [31:0] d, output logic [31:0] rd, output logic re);
    int n;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_addr[k] = a; req_size[k] = sz; req_strobe[k] = sb; req_data[k] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_addr_ok[k] && n < 20);
    check("accept_seen", k, 32'(resp_addr_ok[k]), 32'd1);
    @(posedge clk); #1;
    // scrambled fields after acceptance must be ignored
    req_valid[k] = 1'b0; req_addr[k] = $urandom; req_size[k] = 3'($urandom);
    req_strobe[k] = 4'($urandom); req_data[k] = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_data_ok[k] && n < 20);
    check("latency", k, 32'(n), 32'(lat(k)));
    rd = resp_data[k];
    re = resp_err[k];
  endtask

  task automatic rand_phase(input int k, input int n);
    logic [31:0] a, rd;
    logic [2:0]  sz;
    logic [3:0]  sb;
    logic        re;
    int          r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 15)) * 4;
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 3'd1) a = a + 32'($urandom_range(0, 1)) * 2;
      if (r == 1) a = a + 32'($urandom_range(0, 3));
      if (r == 2) a = 32'(mw(k) * 4) + 32'($urandom_range(0, 1000));
      if (r == 3) a = $urandom;
      sb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      txn(k, a, sz, sb, $urandom, rd, re);
    end
  endtask

  logic [31:0] rd;
  logic        re;
  int          n_dok, last_a, last_d, n_a, n_d, low_run, max_low;
  bit          acc;

  initial begin
    for (int k = 0; k < 2; k++) begin
      resetn[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = 32'd0; req_size[k] = 3'd0;
      req_strobe[k] = 4'd0; req_data[k] = 32'd0; pend[k] = 1'b0; cyc[k] = 0; due[k] = 0;
      for (int i = 0; i < 1024; i++) kn[k][i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    #1 resetn[0] = 1'b1; resetn[1] = 1'b1;

    // word write then read back
    txn(0, 32'h10, 3'd2, 4'hF, 32'hDEADBEEF, rd, re);
    check("t1_wr_err", 0, 32'(re), 32'd0);
    txn(0, 32'h10, 3'd2, 4'h0, 32'd0, rd, re);
    check("t1_rd", 0, rd, 32'hDEADBEEF);
    check("t1_rd_err", 0, 32'(re), 32'd0);

    // byte lane 2 merge
    txn(0, 32'h12, 3'd0, 4'h4, 32'h00AA0000, rd, re);
    txn(0, 32'h10, 3'd2, 4'h0, 32'd0, rd, re);
    check("t2_rd", 0, rd, 32'hDEAABEEF);

    // misaligned and illegal size
    txn(0, 32'h13, 3'd2, 4'h0, 32'd0, rd, re);
    check("t3_mis_err", 0, 32'(re), 32'd1);
    check("t3_mis_data", 0, rd, 32'd0);
    txn(0, 32'h20, 3'd3, 4'h0, 32'd0, rd, re);
    check("t3_sz_err", 0, 32'(re), 32'd1);
    check("t3_sz_data", 0, rd, 32'd0);
    txn(0, 32'h10, 3'd2, 4'h0, 32'd0, rd, re);
    check("t3_rd", 0, rd, 32'hDEAABEEF);

    // out of range write must not alias onto word 0
    txn(0, 32'h0, 3'd2, 4'hF, 32'h0BADF00D, rd, re);
    txn(0, 32'(MW_A * 4), 3'd2, 4'hF, 32'hFFFFFFFF, rd, re);
    check("t4_oor_err", 0, 32'(re), 32'd1);
    txn(0, 32'h0, 3'd2, 4'h0, 32'd0, rd, re);
    check("t4_rd", 0, rd, 32'h0BADF00D);

    // reset during WAIT of a write
    txn(0, 32'h40, 3'd2, 4'hF, 32'h0, rd, re);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 32'h40; req_size[0] = 3'd2;
    req_strobe[0] = 4'hF; req_data[0] = 32'h12345678;
    @(negedge clk);
    check("t6_accept", 0, 32'(resp_addr_ok[0]), 32'd1);
    @(posedge clk); #1;
    #1 resetn[0] = 1'b0;
    @(negedge clk);
    check("t6_rst_dok", 0, 32'(resp_data_ok[0]), 32'd0);
    check("t6_rst_aok", 0, 32'(resp_addr_ok[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1 req_valid[0] = 1'b0; resetn[0] = 1'b1;
    n_dok = 0;
    repeat (4) begin @(negedge clk); if (resp_data_ok[0]) n_dok++; end
    check("t6_no_dok", 0, 32'(n_dok), 32'd0);
    txn(0, 32'h40, 3'd2, 4'h0, 32'd0, rd, re);
    check("t6_rd", 0, rd, 32'd0);
    check("t6_rd_err", 0, 32'(re), 32'd0);

    // back-to-back reads with req_valid held high, LATENCY 1
    for (int i = 0; i < 8; i++) txn(1, 32'(i * 4), 3'd2, 4'hF, $urandom, rd, re);
    last_a = -1; last_d = -1; n_a = 0; n_d = 0; low_run = 0; max_low = 0;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 32'd0; req_size[1] = 3'd2; req_strobe[1] = 4'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = resp_addr_ok[1];
      if (acc) begin
        if (last_a >= 0) check("t5_aok_gap", 1, 32'(c - last_a), 32'd2);
        last_a = c; n_a++;
      end
      if (resp_data_ok[1]) begin
        if (last_d >= 0) check("t5_dok_gap", 1, 32'(c - last_d), 32'd2);
        last_d = c; n_d++;
      end
      if (!busy[1]) low_run++; else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      @(posedge clk); #1;
      if (acc) req_addr[1] = 32'($urandom_range(0, 7)) * 4;
    end
    req_valid[1] = 1'b0;
    check("t5_n_accept", 1, 32'(n_a), 32'd20);
    check("t5_n_dok", 1, 32'(n_d), 32'd20);
    check("t5_busy_gap", 1, 32'(max_low), 32'd1);

    rand_phase(0, 150);
    rand_phase(1, 150);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
